// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch squash,
// multdiv freeze with timeout abort, and a saturating stall-cycle counter.
module pipeline_stall_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             is_bypass_hazard,
    input  logic             dx_is_md,
    input  logic             md_ready,
    input  logic             branch_taken,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             dx_bubble,
    output logic             fd_flush,
    output logic             xm_bubble,
    output logic             md_start,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WC_W = $clog2(MD_TIMEOUT);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MD_TIMEOUT - 1);

    localparam logic [0:0] S_RUN     = 1'b0;
    localparam logic [0:0] S_MD_WAIT = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [WC_W-1:0]  r_wait_cnt;
    logic [WC_W-1:0]  w_wait_nxt;
    logic             r_md_timeout;
    logic             w_abort;
    logic             w_md_start;
    logic [CNT_W-1:0] r_stall_cycles;

    always_comb begin
        pc_en       = 1'b1;
        fd_en       = 1'b1;
        dx_en       = 1'b1;
        dx_bubble   = 1'b0;
        fd_flush    = 1'b0;
        xm_bubble   = 1'b0;
        w_md_start  = 1'b0;
        w_abort     = 1'b0;
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            S_RUN: begin
                // A taken branch squashes the hazard instruction, so it outranks everything.
                if (branch_taken) begin
                    fd_flush  = 1'b1;
                    dx_bubble = 1'b1;
                end else if (dx_is_md) begin
                    w_md_start  = 1'b1;
                    pc_en       = 1'b0;
                    fd_en       = 1'b0;
                    dx_en       = 1'b0;
                    xm_bubble   = 1'b1;
                    w_state_nxt = S_MD_WAIT;
                    w_wait_nxt  = '0;
                end else if (is_bypass_hazard) begin
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    dx_bubble = 1'b1;
                end
            end
            default: begin
                if (md_ready) begin
                    w_state_nxt = S_RUN;
                end else if (r_wait_cnt == WC_LAST) begin
                    xm_bubble   = 1'b1;
                    w_abort     = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    pc_en      = 1'b0;
                    fd_en      = 1'b0;
                    dx_en      = 1'b0;
                    xm_bubble  = 1'b1;
                    w_wait_nxt = r_wait_cnt + 1'b1;
                end
            end
        endcase
    end

    assign md_start     = w_md_start & reset;
    assign md_timeout   = r_md_timeout;
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= S_RUN;
            r_wait_cnt     <= '0;
            r_md_timeout   <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_abort)
                r_md_timeout <= 1'b1;
            if (!pc_en && (r_stall_cycles != {CNT_W{1'b1}}))
                r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench: two configurations driven in lockstep against a cycle-level reference model.
module tb_pipeline_stall_ctrl;

    typedef struct packed {
        logic        pc, fd, dx, dxb, fdf, xmb, mds, mto;
        logic [31:0] cnt;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic haz = 1'b0, md = 1'b0, rdy = 1'b0, br = 1'b0;

    logic pc_a, fd_a, dx_a, dxb_a, fdf_a, xmb_a, mds_a, mto_a;
    logic pc_b, fd_b, dx_b, dxb_b, fdf_b, xmb_b, mds_b, mto_b;
    logic [31:0] cnt_a;
    logic [2:0]  cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t qa[$];
    exp_t qb[$];

    int     T[2] = '{8, 4};
    int     W[2] = '{32, 3};
    bit     m_md[2], n_md[2];
    int     m_st[2], n_st[2];
    bit     m_to[2], n_to[2];
    longint m_cnt[2], n_cnt[2];
    int     cyc = 0;

    always #5 clock = ~clock;

    pipeline_stall_ctrl #(.MD_TIMEOUT(8), .CNT_W(32)) u_a (
        .clock(clock), .reset(reset), .is_bypass_hazard(haz), .dx_is_md(md),
        .md_ready(rdy), .branch_taken(br), .pc_en(pc_a), .fd_en(fd_a), .dx_en(dx_a),
        .dx_bubble(dxb_a), .fd_flush(fdf_a), .xm_bubble(xmb_a), .md_start(mds_a),
        .md_timeout(mto_a), .stall_cycles(cnt_a));

    pipeline_stall_ctrl #(.MD_TIMEOUT(4), .CNT_W(3)) u_b (
        .clock(clock), .reset(reset), .is_bypass_hazard(haz), .dx_is_md(md),
        .md_ready(rdy), .branch_taken(br), .pc_en(pc_b), .fd_en(fd_b), .dx_en(dx_b),
        .dx_bubble(dxb_b), .fd_flush(fdf_b), .xm_bubble(xmb_b), .md_start(mds_b),
        .md_timeout(mto_b), .stall_cycles(cnt_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Model: an md op started at cycle s aborts k=T cycles later unless md_ready came first.
    task automatic model_push(input bit rst);
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            int   k;
            longint maxv;
            if (!rst) begin
                m_md[d] = 0; m_to[d] = 0; m_cnt[d] = 0;
            end
            e = '0;
            e.pc = 1; e.fd = 1; e.dx = 1;
            n_md[d] = m_md[d]; n_st[d] = m_st[d]; n_to[d] = m_to[d];
            if (!m_md[d]) begin
                if (br) begin
                    e.fdf = 1; e.dxb = 1;
                end else if (md) begin
                    e.mds = rst; e.pc = 0; e.fd = 0; e.dx = 0; e.xmb = 1;
                    n_md[d] = 1; n_st[d] = cyc;
                end else if (haz) begin
                    e.pc = 0; e.fd = 0; e.dxb = 1;
                end
            end else begin
                k = cyc - m_st[d];
                if (rdy) begin
                    n_md[d] = 0;
                end else if (k == T[d]) begin
                    e.xmb = 1; n_md[d] = 0; n_to[d] = 1;
                end else begin
                    e.pc = 0; e.fd = 0; e.dx = 0; e.xmb = 1;
                end
            end
            e.mto = m_to[d];
            e.cnt = 32'(m_cnt[d]);
            maxv  = (64'sd1 <<< W[d]) - 1;
            n_cnt[d] = (!e.pc && m_cnt[d] < maxv) ? m_cnt[d] + 1 : m_cnt[d];
            if (!rst) begin
                n_md[d] = 0; n_to[d] = 0; n_cnt[d] = 0;
            end
            if (d == 0) qa.push_back(e);
            else        qb.push_back(e);
        end
    endtask

    task automatic drive(input bit rst, input bit h, input bit m, input bit r, input bit b);
        @(posedge clock);
        for (int d = 0; d < 2; d++) begin
            m_md[d] = n_md[d]; m_st[d] = n_st[d]; m_to[d] = n_to[d]; m_cnt[d] = n_cnt[d];
        end
        cyc++;
        #1;
        reset = rst; haz = h; md = m; rdy = r; br = b;
        model_push(rst);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("A_ctrl", {24'd0, pc_a, fd_a, dx_a, dxb_a, fdf_a, xmb_a, mds_a, mto_a},
                {24'd0, e.pc, e.fd, e.dx, e.dxb, e.fdf, e.xmb, e.mds, e.mto});
            chk("A_stall_cycles", cnt_a, e.cnt);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("B_ctrl", {24'd0, pc_b, fd_b, dx_b, dxb_b, fdf_b, xmb_b, mds_b, mto_b},
                {24'd0, e.pc, e.fd, e.dx, e.dxb, e.fdf, e.xmb, e.mds, e.mto});
            chk("B_stall_cycles", {29'd0, cnt_b}, e.cnt);
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            n_md[d] = 0; n_st[d] = 0; n_to[d] = 0; n_cnt[d] = 0;
        end
        #2 reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);               // md_start must stay low under reset
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);               // single load-use stall
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0);               // md with ready exactly at the abort cycle of B
        repeat (3) drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0);               // md with ready at k=5: B aborts, A completes
        repeat (4) drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        repeat (2) drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 1);               // branch beats hazard
        drive(1, 1, 1, 0, 1);               // branch beats md
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0);               // back-to-back md, k=1 then a fresh start
        drive(1, 0, 1, 1, 0);
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 1, 0, 0);               // reset during 2nd MD_WAIT cycle
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (10) drive(1, 1, 0, 0, 0);   // saturation of the 3-bit counter
        drive(1, 0, 0, 0, 0);
        @(negedge clock);
        #1;
        chk("A_after_10_stalls", cnt_a, 32'd10);
        chk("B_saturated", {29'd0, cnt_b}, 32'd7);
        repeat (3000) begin
            drive(($urandom_range(99) != 0),
                  ($urandom_range(3) == 0),
                  ($urandom_range(9) == 0),
                  ($urandom_range(4) == 0),
                  ($urandom_range(6) == 0));
        end
        drive(1, 0, 0, 0, 0);
        @(negedge clock);
        #1;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d/%0d entries left, expected 0", qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage processor. It consumes the load-use hazard flag from the F/D-vs-D/X comparator, the X-stage redirect, and the multiplier/divider busy handshake. It drives the PC, F/D and D/X latch enables, the bubble and flush controls, and the multdiv start pulse. It also keeps a saturating stall-cycle counter for performance debug.

## Interface

Parameters:
- MD_TIMEOUT, 64: maximum cycles spent in MD_WAIT before the multdiv op is aborted (≥2).
- CNT_W, 32: width of stall_cycles.

Ports:
- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low; one clock, no other clock domains
- is_bypass_hazard  in  1  load-use hazard (lw in D/X, its rd matches an F/D source)
- dx_is_md  in  1  D/X instruction is mul or div
- md_ready  in  1  multdiv result valid this cycle
- branch_taken  in  1  X-stage redirect (taken branch/jump) this cycle
- pc_en  out  1  PC register write enable
- fd_en  out  1  F/D latch enable
- dx_en  out  1  D/X latch enable
- dx_bubble  out  1  load nop into D/X instead of F/D contents
- fd_flush  out  1  load nop into F/D
- xm_bubble  out  1  load nop into X/M
- md_start  out  1  one-cycle start pulse to multdiv
- md_timeout  out  1  sticky: a multdiv op was aborted
- stall_cycles  out  CNT_W  count of cycles with pc_en=0, saturating

## Operation

- State register: RUN, MD_WAIT. Also wait_cnt (clog2(MD_TIMEOUT) bits), md_timeout flag, stall_cycles.
- Outputs are combinational from state and inputs. Default: pc_en=fd_en=dx_en=1, all others 0.
- RUN, priority high→low:
  - branch_taken: fd_flush=1, dx_bubble=1, pc_en=1. is_bypass_hazard is ignored because the hazard instruction is squashed.
  - dx_is_md: md_start=1, pc_en=fd_en=dx_en=0, xm_bubble=1. Next state MD_WAIT, wait_cnt←0.
  - is_bypass_hazard: pc_en=fd_en=0, dx_bubble=1 (exactly one bubble). The D/X lw advances normally.
  - md_ready in RUN is ignored.
- MD_WAIT:
  - md_ready=1: all enables 1, xm_bubble=0 (result enters X/M). Next state RUN.
  - Otherwise, if wait_cnt==MD_TIMEOUT-1 (abort cycle): all enables 1, xm_bubble=1. Next state RUN, md_timeout←1.
  - Otherwise: pc_en=fd_en=dx_en=0, xm_bubble=1, wait_cnt+1.
  - is_bypass_hazard and branch_taken are ignored; the pipeline is frozen.
- md_ready wins over abort in the same cycle.
- Back-to-back mul/div: after completion the next D/X instruction is evaluated fresh in RUN. A second md starts on the following cycle.
- stall_cycles increments on each edge where pc_en=0. It holds at 2^CNT_W−1.
- md_timeout clears only on reset.

## Timing

- Reset (reset=0, async): state=RUN, wait_cnt=0, md_timeout=0, stall_cycles=0. md_start is forced 0 while reset is low.
- Outputs with reset low and inputs 0: pc_en=fd_en=dx_en=1, dx_bubble=fd_flush=xm_bubble=md_start=0.
- Load-use stall: 0-cycle response (same cycle as the flag), 1 stall cycle.
- Multdiv: the start cycle is stalled. If md_ready arrives k cycles after md_start, stall = k cycles. Minimum k=1; maximum k=MD_TIMEOUT, which is the abort cycle.
- Reset asserted mid-MD_WAIT: return to RUN immediately. No md_start on release unless dx_is_md is still high in RUN.

## Test plan

- Load-use stall: is_bypass_hazard=1 for one cycle in RUN → pc_en=fd_en=0 and dx_bubble=1 that cycle only; stall_cycles 0→1.
- Multdiv completion: dx_is_md=1, md_ready 5 cycles after md_start → md_start high 1 cycle; pc_en low 5 cycles; xm_bubble=0 and enables 1 in the md_ready cycle; stall_cycles=5; state RUN.
- Timeout: MD_TIMEOUT=4, md_ready never asserted → abort on 4th MD_WAIT cycle; md_timeout=1 thereafter; stall_cycles=4. md_ready in the abort cycle instead → md_timeout stays 0.
- Branch priority: branch_taken=1 with is_bypass_hazard=1 → fd_flush=1, dx_bubble=1, pc_en=1; stall_cycles unchanged.
- Reset mid-op: reset low on 2nd MD_WAIT cycle → state RUN, stall_cycles=0, md_timeout=0 asynchronously. Release with dx_is_md=0 → normal RUN outputs.
- Saturation: CNT_W=3, 10 load-use stalls → stall_cycles=7.
